mem_arbiter: RTL

- Shares the single RAM port between the instruction cache (read-only fill requests) and the data cache (read/write).
- Sits between the icache/dcache `caches_if` memory-side signals and the RAM model.
- Grants one requester at a time through a registered FSM and holds the grant until the RAM reports ACCESS.
- Data side has priority, bounded by a starvation limit so instruction fetch always progresses.

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Memory-side bundle between the icache/dcache, the RAM port and mem_arbiter.
// MEM_ARBITER_STATS_EN adds the istat/dstat completion counters.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] istat;
  logic [31:0] dstat;
`endif

  // Arbiter side.
  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
`ifdef MEM_ARBITER_STATS_EN
    , output istat, dstat
`endif
  );

  // Cache/RAM side.
  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
`ifdef MEM_ARBITER_STATS_EN
    , input istat, dstat
`endif
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache fills and dcache accesses; data side first, bounded burst.
// Optional MEM_ARBITER_STATS_EN adds saturating completion counters istat/dstat.
module mem_arbiter #(
  parameter int unsigned MAX_DBURST = 4
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIServ = 2'd1,
    StDServ = 2'd2
  } state_t;

  localparam logic [1:0] RamAccess = 2'd2;

  state_t      state_q, state_d;
  logic [3:0]  dcnt_q, dcnt_d;

  logic        dreq;
  logic        burst_ok;
  logic [3:0]  dcnt_inc;
  logic        ram_access;

  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store;

  assign dreq       = bus.dREN | bus.dWEN;
  assign burst_ok   = {28'd0, dcnt_q} < MAX_DBURST;
  assign dcnt_inc   = (dcnt_q == 4'hF) ? dcnt_q : dcnt_q + 4'd1;
  assign ram_access = (bus.ramstate == RamAccess);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      dcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Serve-state outputs follow the granted requester combinationally; strobes are never
  // driven in StIdle, so ACCESS seen there has no effect.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = 32'd0;
    dload     = 32'd0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = 32'd0;
    ram_store = 32'd0;

    case (state_q)
      StIdle: begin
        if (dreq && (!bus.iREN || burst_ok)) begin
          state_d = StDServ;
        end else if (bus.iREN) begin
          state_d = StIServ;
        end
      end

      StIServ: begin
        if (!bus.iREN) begin
          state_d = StIdle;
        end else begin
          ram_ren  = 1'b1;
          ram_addr = bus.iaddr;
          if (ram_access) begin
            iwait   = 1'b0;
            iload   = bus.ramload;
            dcnt_d  = 4'd0;
            state_d = StIdle;
          end
        end
      end

      StDServ: begin
        if (!dreq) begin
          state_d = StIdle;
        end else begin
          ram_addr = bus.daddr;
          if (bus.dWEN) begin
            ram_wen   = 1'b1;
            ram_store = bus.dstore;
          end else begin
            ram_ren = 1'b1;
          end
          if (ram_access) begin
            dwait   = 1'b0;
            dload   = bus.dWEN ? 32'd0 : bus.ramload;
            // Only a waiting icache makes the burst count matter.
            dcnt_d  = bus.iREN ? dcnt_inc : 4'd0;
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.iwait    = iwait;
  assign bus.dwait    = dwait;
  assign bus.iload    = iload;
  assign bus.dload    = dload;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] istat_q, dstat_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      istat_q <= 32'd0;
      dstat_q <= 32'd0;
    end else begin
      if (!iwait && (istat_q != 32'hFFFF_FFFF)) istat_q <= istat_q + 32'd1;
      if (!dwait && (dstat_q != 32'hFFFF_FFFF)) dstat_q <= dstat_q + 32'd1;
    end
  end

  assign bus.istat = istat_q;
  assign bus.dstat = dstat_q;
`endif

endmodule
